// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: sequences one MEM-stage load/store onto a single-beat 64-bit
// valid/ready bus, stalls the pipeline while it is outstanding and hands the
// raw read doubleword plus the unshifted byte-enable to the WB result mux.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests complete
// immediately with misalign=1 instead of being issued on the bus).
module lsu_bus_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] mem_data,
  output logic [7:0]        byte_enable,
  output logic              misalign,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                misalign_req_s;
  logic [7:0]          req_be_s;
  logic [5:0]          shamt_s;
  logic                done_r;
  logic                misalign_r;
  logic                bus_valid_r;
  logic                bus_we_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [DATA_W-1:0]   bus_wdata_r;
  logic [7:0]          bus_wstrb_r;
  logic [DATA_W-1:0]   mem_data_r;
  logic [7:0]          byte_enable_r;

  // Unshifted byte-enable for an access size.
  function automatic logic [7:0] size_be_f(input logic [1:0] size);
    logic [7:0] be;
    case (size)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      2'd3:    be = 8'hFF;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned_f(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      2'd3:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  assign req_be_s = size_be_f(req_size);
  assign shamt_s  = {req_addr[2:0], 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_req_s = is_misaligned_f(req_size, req_addr[2:0]);
`else
  // Misaligned requests go out normally; out-of-doubleword bytes fall off the shifts.
  assign misalign_req_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; bus_ready/bus_rvalid only matter in REQ/RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (misalign_req_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus_ready) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = REQ;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request latch, bus request holding, response capture and completion pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_r        <= 1'b0;
      misalign_r    <= 1'b0;
      bus_valid_r   <= 1'b0;
      bus_we_r      <= 1'b0;
      bus_addr_r    <= {ADDR_W{1'b0}};
      bus_wdata_r   <= {DATA_W{1'b0}};
      bus_wstrb_r   <= 8'h00;
      mem_data_r    <= {DATA_W{1'b0}};
      byte_enable_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
          if (req_valid) begin
            byte_enable_r <= req_be_s;
            if (misalign_req_s) begin
              done_r     <= 1'b1;
              misalign_r <= 1'b1;
            end else begin
              bus_valid_r <= 1'b1;
              bus_we_r    <= req_we;
              bus_addr_r  <= {req_addr[ADDR_W-1:3], 3'b000};
              bus_wdata_r <= req_wdata << shamt_s;
              bus_wstrb_r <= req_be_s << req_addr[2:0];
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid_r <= 1'b0;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            done_r <= 1'b1;
            if (!bus_we_r) begin
              mem_data_r <= bus_rdata;
            end
          end
        end
        DONE: begin
          done_r     <= 1'b0;
          misalign_r <= 1'b0;
        end
        default: begin
          done_r      <= 1'b0;
          misalign_r  <= 1'b0;
          bus_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign stall = ((state_r == IDLE) && req_valid) || (state_r == REQ) || (state_r == RESP);

  assign done        = done_r;
  assign misalign    = misalign_r;
  assign bus_valid   = bus_valid_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign bus_wstrb   = bus_wstrb_r;
  assign mem_data    = mem_data_r;
  assign byte_enable = byte_enable_r;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed testbench for lsu_bus_ctrl with a completion scoreboard.
module tb_lsu_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        done;
  logic [63:0] mem_data;
  logic [7:0]  byte_enable;
  logic        misalign;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  lsu_bus_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .mem_data(mem_data),
    .byte_enable(byte_enable), .misalign(misalign),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] mem;
    logic [7:0]  be;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_mem = 64'h0;
  int          checks    = 0;
  int          failures  = 0;
  int          hs_cnt    = 0;
  int          hs_base   = 0;

  // Count bus handshakes as the DUT sees them at the clock edge.
  always @(posedge clock) begin
    if (bus_valid && bus_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] be_of(input logic [1:0] size);
    logic [7:0] t [4];
    t[0] = 8'h01; t[1] = 8'h03; t[2] = 8'h0F; t[3] = 8'hFF;
    return t[size];
  endfunction

  // Drive a request and push the expected completion result.
  task automatic issue(input logic we, input logic [1:0] size, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    if (!we) model_mem = rdata;
    sb.push_back('{mem: model_mem, be: be_of(size)});
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_stall"}, stall, 1'b0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_mem_data"}, mem_data, e.mem);
      chk({tag, "_byte_enable"}, byte_enable, e.be);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 64'h0; req_wdata = 64'h0; bus_ready = 1'b0;
    bus_rvalid = 1'b0; bus_rdata = 64'h0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_data", mem_data, 64'h0);
    chk("rst_byte_enable", byte_enable, 8'h00);
    chk("rst_bus_wstrb", bus_wstrb, 8'h00);

    // T1: load word at 0x1004, minimum latency
    issue(1'b0, 2'd2, 64'h1004, 64'h0, 64'h89ABCDEF_01234567);
    bus_ready = 1'b1;
    #1 chk("t1_c0_stall", stall, 1'b1);
    tick();
    chk("t1_c1_bus_valid", bus_valid, 1'b1);
    chk("t1_c1_bus_addr", bus_addr, 64'h1000);
    chk("t1_c1_bus_wstrb", bus_wstrb, 8'hF0);
    chk("t1_c1_bus_we", bus_we, 1'b0);
    chk("t1_c1_stall", stall, 1'b1);
    chk("t1_c1_done", done, 1'b0);
    tick();
    chk("t1_c2_bus_valid", bus_valid, 1'b0);
    chk("t1_c2_stall", stall, 1'b1);
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h89ABCDEF_01234567;
    tick();
    check_done("t1_c3");
    bus_rvalid = 1'b0; req_valid = 1'b0;
    tick();
    chk("t1_c4_done", done, 1'b0);
    chk("t1_c4_mem_hold", mem_data, 64'h89ABCDEF_01234567);

    // T2: store byte 0xA5 at 0x2003, bus_ready delayed 4 cycles
    issue(1'b1, 2'd0, 64'h2003, 64'h0000_0000_0000_00A5, 64'h0);
    tick();
    req_addr = 64'h7777; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_size = 2'd3;
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_bus_valid", bus_valid, 1'b1);
      chk("t2_wait_bus_addr", bus_addr, 64'h2000);
      chk("t2_wait_bus_wdata", bus_wdata, 64'h0000_0000_A500_0000);
      chk("t2_wait_bus_wstrb", bus_wstrb, 8'h08);
      chk("t2_wait_bus_we", bus_we, 1'b1);
      chk("t2_wait_stall", stall, 1'b1);
      tick();
    end
    chk("t2_hs_bus_valid", bus_valid, 1'b1);
    chk("t2_hs_bus_wdata", bus_wdata, 64'h0000_0000_A500_0000);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("t2_resp_bus_valid", bus_valid, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    check_done("t2_done");
    bus_rvalid = 1'b0; req_valid = 1'b0;
    tick();

    // T3: back-to-back loads with req_valid held through DONE
    hs_base = hs_cnt;
    issue(1'b0, 2'd3, 64'h5000, 64'h0, 64'h1111_2222_3333_4444);
    bus_ready = 1'b1;
    tick();
    chk("t3_a_bus_addr", bus_addr, 64'h5000);
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h1111_2222_3333_4444;
    tick();
    bus_rvalid = 1'b0;
    check_done("t3_a");
    issue(1'b0, 2'd1, 64'h5008, 64'h0, 64'h5555_6666_7777_8888);
    bus_ready = 1'b1;
    tick();
    chk("t3_idle_bus_valid", bus_valid, 1'b0);
    chk("t3_idle_done", done, 1'b0);
    chk("t3_idle_stall", stall, 1'b1);
    tick();
    chk("t3_b_bus_valid", bus_valid, 1'b1);
    chk("t3_b_bus_addr", bus_addr, 64'h5008);
    chk("t3_b_bus_wstrb", bus_wstrb, 8'h03);
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h5555_6666_7777_8888;
    tick();
    bus_rvalid = 1'b0; req_valid = 1'b0;
    check_done("t3_b");
    tick();
    chk("t3_handshakes", hs_cnt - hs_base, 64'd2);
    chk("t3_end_stall", stall, 1'b0);

    // T4: halfword load at 0x3001 (misaligned)
`ifdef LSU_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_addr = 64'h3001;
    bus_ready = 1'b1;
    #1 chk("t4_c0_stall", stall, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("t4_c1_done", done, 1'b1);
    chk("t4_c1_misalign", misalign, 1'b1);
    chk("t4_c1_bus_valid", bus_valid, 1'b0);
    chk("t4_c1_mem_data", mem_data, model_mem);
    tick();
    chk("t4_c2_misalign", misalign, 1'b0);
    chk("t4_c2_bus_valid", bus_valid, 1'b0);
    bus_ready = 1'b0;
`else
    issue(1'b0, 2'd1, 64'h3001, 64'h0, 64'hCAFE_F00D_0BAD_BEEF);
    bus_ready = 1'b1;
    tick();
    chk("t4_bus_wstrb", bus_wstrb, 8'h06);
    chk("t4_bus_addr", bus_addr, 64'h3000);
    chk("t4_misalign", misalign, 1'b0);
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    tick();
    bus_rvalid = 1'b0; req_valid = 1'b0;
    check_done("t4");
    chk("t4_done_misalign", misalign, 1'b0);
    tick();
`endif

    // T5: double store at 0x4000
    issue(1'b1, 2'd3, 64'h4000, 64'h1122334455667788, 64'h0);
    bus_ready = 1'b1;
    tick();
    chk("t5_bus_wstrb", bus_wstrb, 8'hFF);
    chk("t5_bus_wdata", bus_wdata, 64'h1122334455667788);
    chk("t5_bus_we", bus_we, 1'b1);
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h0123_0123_0123_0123;
    tick();
    bus_rvalid = 1'b0; req_valid = 1'b0;
    check_done("t5");
    tick();

    // T6: reset asserted while in RESP
    issue(1'b0, 2'd2, 64'h6000, 64'h0, 64'h0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; req_valid = 1'b0;
    tick();
    chk("t6_pre_stall", stall, 1'b1);
    reset = 1'b1;
    #1;
    sb.delete();
    model_mem = 64'h0;
    chk("t6_rst_stall", stall, 1'b0);
    chk("t6_rst_bus_addr", bus_addr, 64'h0);
    chk("t6_rst_bus_we", bus_we, 1'b0);
    chk("t6_rst_bus_wdata", bus_wdata, 64'h0);
    chk("t6_rst_mem_data", mem_data, 64'h0);
    chk("t6_rst_byte_enable", byte_enable, 8'h00);
    tick();
    reset = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'hABCD_ABCD_ABCD_ABCD;
    tick();
    chk("t6_post_done", done, 1'b0);
    chk("t6_post_stall", stall, 1'b0);
    bus_rvalid = 1'b0;
    tick();
    chk("t6_post2_done", done, 1'b0);
    chk("t6_post2_mem_data", mem_data, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Sequences one load or store from the MEM stage onto a single-beat, 64-bit data bus with a valid/ready handshake.
- Stalls the pipeline while the access is outstanding.
- Aligns store data and byte strobes to the bus doubleword.
- Captures the returned read doubleword and presents it, with the unshifted byte-enable, to the WB-stage result mux. That mux performs the shift and sign/zero extension.

Parameters:
- ADDR_W, 64, width of request and bus address.
- DATA_W, 64, width of data paths; fixed at 64 (strobe logic assumes 8 bytes).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage holds a load/store
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- stall  out  1  freeze pipeline
- done  out  1  one-cycle completion pulse
- mem_data  out  DATA_W  captured raw bus doubleword (unshifted)
- byte_enable  out  8  0x01/0x03/0x0F/0xFF per latched size
- misalign  out  1  misaligned-access flag (see Optional Feature)
- bus_valid  out  1  request valid
- bus_ready  in  1  bus accepts request
- bus_we  out  1  write request
- bus_addr  out  ADDR_W  {addr[ADDR_W-1:3],3'b000}
- bus_wdata  out  DATA_W  req_wdata << (addr[2:0]*8)
- bus_wstrb  out  8  (byte_enable << addr[2:0]) truncated to 8 bits
- bus_rvalid  in  1  response/read data valid (loads and stores)
- bus_rdata  in  DATA_W  read data

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All registered outputs are 0: bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, mem_data, byte_enable, done, misalign.
  - Takes effect immediately, including mid-transaction. An in-flight bus transaction is abandoned; the bus side is reset by the same signal.
- State machine: IDLE, REQ, RESP, DONE.
- IDLE:
  - On req_valid, latch we, size, addr and wdata. Compute bus_addr, bus_wdata, bus_wstrb and byte_enable. Go to REQ.
- REQ:
  - bus_valid=1. All bus request outputs are held stable until bus_ready.
  - On bus_valid&bus_ready, drop bus_valid next cycle and go to RESP.
- RESP:
  - Wait for bus_rvalid, with no timeout.
  - On bus_rvalid: for a load, mem_data<=bus_rdata; for a store, mem_data is unchanged. Go to DONE.
  - bus_rvalid in the same cycle as the REQ handshake is not accepted; the response is accepted in RESP only.
- DONE:
  - done=1 for exactly this cycle, then go to IDLE.
  - req_valid in DONE is ignored; it belongs to the instruction leaving MEM this cycle.
- stall (combinational) = (state==IDLE & req_valid) | state==REQ | state==RESP. stall is 0 in DONE.
- mem_data and byte_enable hold their values after DONE until the next load completes or is latched.
- Minimum latency, with bus_ready=1 in REQ and bus_rvalid on the next cycle: req seen in cycle 0, handshake in cycle 1, rvalid in cycle 2, done in cycle 3. The pipeline is stalled for 3 cycles.
- bus_ready outside REQ and bus_rvalid outside RESP are ignored.
- Unsupported encodings: none; all 4 size codes are valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a request with addr[2:0] not a multiple of (1<<size) issues no bus transaction.
  - The FSM goes directly to DONE, with misalign=1 and done=1 for that cycle.
  - mem_data is unchanged.
- Undefined:
  - misalign is tied to 0.
  - A misaligned request is issued normally. Strobes and data shifted beyond byte 7 are dropped.

Test Plan:
- Load word at 0x1004, bus_ready=1 immediately, bus_rvalid next cycle with rdata=0x89ABCDEF_01234567:
  - bus_addr=0x1000, bus_wstrb=0xF0, bus_we=0.
  - done in cycle 3, mem_data=0x89ABCDEF_01234567, byte_enable=0x0F.
  - stall high for cycles 0-2.
- Store byte 0xA5 at 0x2003, bus_ready delayed 4 cycles:
  - bus_valid and all request signals stable throughout, bus_wdata[31:24]=0xA5, bus_wstrb=0x08.
  - After rvalid, done pulses and mem_data is unchanged.
- Back-to-back loads with req_valid held through DONE:
  - The DONE-cycle req_valid is ignored.
  - The second access starts from IDLE on the following cycle; exactly two bus handshakes occur.
- Assert reset while in RESP:
  - Outputs are 0 immediately, state is IDLE.
  - A subsequent bus_rvalid is ignored and does not produce done.
- Halfword load at 0x3001 (misaligned):
  - With LSU_MISALIGN_TRAP_EN: no bus_valid, done and misalign pulse in cycle 1.
  - Without it: bus_wstrb=0x06, misalign=0.
- Double store at 0x4000, data 0x1122334455667788:
  - bus_wstrb=0xFF, bus_wdata equals the input unshifted.
